inst_fetch_sequencer: RTL and testbench

//  Sequences byte-wide reads from the instruction memory. Assembles four consecutive

---
 rtl/inst_fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_inst_fetch_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_sequencer.sv
// Byte-serial instruction fetch: assembles four little-endian bytes per instruction.
// Optional misaligned-redirect trap (sticky fetch_fault + HALT) under `ALIGN_CHECK_EN.
module inst_fetch_sequencer #(
  parameter int                ADDR_W    = 64,
  parameter int                MEM_BYTES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_fault
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);

`ifdef ALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, VALID, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        cnt_q;
  logic [1:0]        lane;
  logic              handshake;
  logic              redirect_take;
  logic              misalign;
  logic              fault_q;

  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    return a & ADDR_MASK;
  endfunction

  assign handshake = inst_valid & inst_ready;
  assign lane      = cnt_q - 2'd1;

`ifdef ALIGN_CHECK_EN
  assign redirect_take = redirect_valid && (state_q != HALT);
  assign misalign      = redirect_pc[1:0] != 2'b00;
`else
  assign redirect_take = redirect_valid;
  assign misalign      = 1'b0;
`endif

  assign fetch_fault = fault_q;
  assign mem_rd_en   = (state_q == FETCH);
  assign mem_addr    = (state_q == FETCH) ? wrap_addr(pc_q + ADDR_W'(cnt_q)) : addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en) state_d = FETCH;
      FETCH:   if (cnt_q == 2'd3) state_d = DRAIN;
      DRAIN:   state_d = VALID;
      VALID:   if (handshake) state_d = fetch_en ? FETCH : IDLE;
      default: state_d = state_q;
    endcase
    // A redirect overrides whatever the sequence was doing.
    if (redirect_take) begin
`ifdef ALIGN_CHECK_EN
      if (misalign) state_d = HALT;
      else          state_d = fetch_en ? FETCH : IDLE;
`else
      state_d = fetch_en ? FETCH : IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= wrap_addr(RESET_PC);
      addr_q     <= '0;
      cnt_q      <= 2'd0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (state_q == FETCH) addr_q <= mem_addr;
      if (redirect_take) begin
        // Partial bytes and any read still in flight are simply abandoned.
        pc_q       <= wrap_addr(redirect_pc);
        cnt_q      <= 2'd0;
        inst_valid <= 1'b0;
        if (misalign) fault_q <= 1'b1;
      end else begin
        case (state_q)
          FETCH: begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q != 2'd0) inst_data[{lane, 3'b000} +: 8] <= mem_rdata;
          end
          DRAIN: begin
            inst_data[31:24] <= mem_rdata;
            inst_pc          <= pc_q;
            inst_valid       <= 1'b1;
            cnt_q            <= 2'd0;
          end
          VALID: begin
            if (handshake) begin
              pc_q       <= wrap_addr(pc_q + ADDR_W'(4));
              inst_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Directed bench for inst_fetch_sequencer against a 16-byte, 1-cycle-latency memory.
// Build with +define+ALIGN_CHECK_EN to exercise the misalignment trap.
module tb_inst_fetch_sequencer;
  localparam int ADDR_W = 64;

  logic              clk;
  logic              reset;
  logic              fetch_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              fetch_fault;

  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  int          col_first, col_vcyc, col_n, col_oob;
  logic [31:0] col_data;
  logic [63:0] col_pc;
  logic [63:0] col_addr [8];

  inst_fetch_sequencer #(.ADDR_W(64), .MEM_BYTES(16), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples the current cycle first, then advances; stops on the first valid cycle.
  task automatic collect(input int budget);
    col_first = -1; col_vcyc = -1; col_n = 0; col_oob = 0;
    col_data = '0; col_pc = '0;
    for (int c = 0; c < budget; c++) begin
      if (mem_rd_en) begin
        if (col_first < 0) col_first = c;
        if (col_n < 8) col_addr[col_n] = mem_addr;
        col_n++;
        if (mem_addr >= 64'd16) col_oob++;
      end
      if (inst_valid) begin
        col_vcyc = c; col_data = inst_data; col_pc = inst_pc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    tick(); tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", inst_data); end
    checks++; if (inst_pc !== 64'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", inst_pc); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b want 0", mem_rd_en); end
    checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", fetch_fault); end
  endtask

  task automatic test_basic();
    fetch_en = 1'b1; inst_ready = 1'b1; reset = 1'b1;
    collect(20);
    checks++; if (col_vcyc - col_first !== 5) begin errors++; $display("FAIL t1_latency got %0d want 5", col_vcyc - col_first); end
    checks++; if (col_n !== 4) begin errors++; $display("FAIL t1_reads got %0d want 4", col_n); end
    checks++;
    if ({col_addr[0][7:0], col_addr[1][7:0], col_addr[2][7:0], col_addr[3][7:0]} !== 32'h00010203) begin
      errors++; $display("FAIL t1_addrs got %0d %0d %0d %0d want 0 1 2 3", col_addr[0], col_addr[1], col_addr[2], col_addr[3]);
    end
    checks++; if (col_data !== 32'h00B504B3) begin errors++; $display("FAIL t1_data0 got %h want 00b504b3", col_data); end
    checks++; if (col_pc !== 64'd0) begin errors++; $display("FAIL t1_pc0 got %0d want 0", col_pc); end
    tick();
    collect(20);
    checks++; if (col_vcyc !== 5 || col_first !== 0) begin errors++; $display("FAIL t1_throughput got first %0d valid %0d want 0 5", col_first, col_vcyc); end
    checks++; if (col_data !== 32'h40D48633) begin errors++; $display("FAIL t1_data1 got %h want 40d48633", col_data); end
    checks++; if (col_pc !== 64'd4) begin errors++; $display("FAIL t1_pc1 got %0d want 4", col_pc); end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inst_valid !== 1'b1 || inst_data !== 32'h40D48633 || inst_pc !== 64'd4 || mem_rd_en !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t2_hold got %0d bad cycles want 0", bad); end
    inst_ready = 1'b1;
    tick();
    collect(20);
    checks++; if (col_addr[0] !== 64'd8 || col_first !== 0) begin errors++; $display("FAIL t2_next_addr got %0d want 8", col_addr[0]); end
    checks++; if (col_data !== 32'h009666B3 || col_pc !== 64'd8) begin errors++; $display("FAIL t2_next_inst got %h@%0d want 009666b3@8", col_data, col_pc); end
  endtask

  task automatic test_wrap();
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'd14;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL t3_valid_drop got %0b want 0", inst_valid); end
    collect(20);
    checks++;
    if ({col_addr[0][7:0], col_addr[1][7:0], col_addr[2][7:0], col_addr[3][7:0]} !== 32'h0E0F0001 || col_oob !== 0) begin
      errors++; $display("FAIL t3_addrs got %0d %0d %0d %0d want 14 15 0 1", col_addr[0], col_addr[1], col_addr[2], col_addr[3]);
    end
    checks++; if (col_data !== 32'h04B30010 || col_pc !== 64'd14) begin errors++; $display("FAIL t3_inst got %h@%0d want 04b30010@14", col_data, col_pc); end
    tick();
    collect(20);
    checks++; if (col_pc !== 64'd2 || col_addr[0] !== 64'd2 || col_data !== 32'h863300B5) begin
      errors++; $display("FAIL t3_pc_wrap got %h@%0d want 863300b5@2", col_data, col_pc);
    end
  endtask

  task automatic test_redirect_mid();
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'd4;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    tick(); tick();
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 64'd6) begin errors++; $display("FAIL t4_cnt2_addr got %0d want 6", mem_addr); end
    redirect_valid = 1'b1; redirect_pc = 64'd8;
    tick();
    redirect_valid = 1'b0;
    collect(20);
    checks++; if (col_pc !== 64'd8 || col_addr[0] !== 64'd8) begin errors++; $display("FAIL t4_pc got %0d want 8", col_pc); end
    checks++; if (col_data !== 32'h009666B3) begin errors++; $display("FAIL t4_data got %h want 009666b3", col_data); end
  endtask

  task automatic test_redirect_handshake_and_reset();
    redirect_valid = 1'b1; redirect_pc = 64'd4;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || mem_addr !== 64'd4) begin errors++; $display("FAIL t5_redirect_addr got %0d want 4", mem_addr); end
    collect(20);
    checks++; if (col_pc !== 64'd4 || col_data !== 32'h40D48633) begin errors++; $display("FAIL t5_inst got %h@%0d want 40d48633@4", col_data, col_pc); end
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (mem_rd_en !== 1'b0 || mem_addr !== 64'd0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 64'd0 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL t5_async_reset got rd %0b addr %0d v %0b d %h pc %0d want all 0", mem_rd_en, mem_addr, inst_valid, inst_data, inst_pc);
    end
    tick();
    reset = 1'b1;
    collect(20);
    checks++; if (col_pc !== 64'd0 || col_addr[0] !== 64'd0 || col_data !== 32'h00B504B3) begin
      errors++; $display("FAIL t5_restart got %h@%0d want 00b504b3@0", col_data, col_pc);
    end
  endtask

  task automatic test_fetch_stop();
    int bad;
    bad = 0;
    tick(); tick();
    fetch_en = 1'b0;
    collect(20);
    checks++; if (col_pc !== 64'd4 || col_data !== 32'h40D48633) begin errors++; $display("FAIL stop_completes got %h@%0d want 40d48633@4", col_data, col_pc); end
    tick();
    for (int i = 0; i < 5; i++) begin
      if (mem_rd_en !== 1'b0 || inst_valid !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stop_idle got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_align();
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'd5;
    tick();
    redirect_valid = 1'b0;
`ifdef ALIGN_CHECK_EN
    begin
      int bad;
      bad = 0;
      checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL t6_fault got %0b want 1", fetch_fault); end
      for (int i = 0; i < 10; i++) begin
        redirect_valid = (i == 3); redirect_pc = 64'd0;
        if (mem_rd_en !== 1'b0 || inst_valid !== 1'b0 || fetch_fault !== 1'b1) bad++;
        tick();
      end
      redirect_valid = 1'b0;
      checks++; if (bad !== 0) begin errors++; $display("FAIL t6_halt got %0d bad cycles want 0", bad); end
      reset = 1'b0;
      #1;
      checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL t6_fault_clear got %0b want 0", fetch_fault); end
      tick();
      reset = 1'b1;
    end
`else
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL t6_fault got %0b want 0", fetch_fault); end
    collect(20);
    checks++;
    if ({col_addr[0][7:0], col_addr[1][7:0], col_addr[2][7:0], col_addr[3][7:0]} !== 32'h05060708) begin
      errors++; $display("FAIL t6_addrs got %0d %0d %0d %0d want 5 6 7 8", col_addr[0], col_addr[1], col_addr[2], col_addr[3]);
    end
    checks++; if (col_data !== 32'hB340D486 || col_pc !== 64'd5) begin errors++; $display("FAIL t6_inst got %h@%0d want b340d486@5", col_data, col_pc); end
`endif
  endtask

  initial begin
    mem[0]  = 8'hB3; mem[1]  = 8'h04; mem[2]  = 8'hB5; mem[3]  = 8'h00;
    mem[4]  = 8'h33; mem[5]  = 8'h86; mem[6]  = 8'hD4; mem[7]  = 8'h40;
    mem[8]  = 8'hB3; mem[9]  = 8'h66; mem[10] = 8'h96; mem[11] = 8'h00;
    mem[12] = 8'h13; mem[13] = 8'h05; mem[14] = 8'h10; mem[15] = 8'h00;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_redirect_mid();
    test_redirect_handshake_and_reset();
    test_fetch_stop();
    test_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
